// File: rtl/iot_filt_pkg.sv
// iot_filt_pkg
// Shared types and constants for the IoT stream filter.
//   fn_e        : function code presented on fn_sel and held in the round latch
//   EXTRACT_*   : default extract window bounds (128-bit samples)
//   EXCLUDE_*   : default exclude window bounds (128-bit samples)
package iot_filt_pkg;

    typedef enum logic [2:0] {
        FN_IDLE    = 3'd0,
        FN_MAX     = 3'd1,
        FN_MIN     = 3'd2,
        FN_AVG     = 3'd3,
        FN_EXTRACT = 3'd4,
        FN_EXCLUDE = 3'd5,
        FN_PEAKMAX = 3'd6,
        FN_PEAKMIN = 3'd7
    } fn_e;

    localparam logic [127:0] EXTRACT_LO = {4'h6, {124{1'b1}}};
    localparam logic [127:0] EXTRACT_HI = {4'hA, {124{1'b1}}};
    localparam logic [127:0] EXCLUDE_LO = {4'h4, 124'd0};
    localparam logic [127:0] EXCLUDE_HI = {4'hC, 124'd0};

endpackage

// File: rtl/iot_filter_engine_deser.sv
// iot_filt_deser
// Collects IN_W-bit beats (most-significant slice first) into one DATA_W-bit
// sample and holds it with sample_vld until the parent takes it.
// Requires DATA_W/IN_W >= 2.
//   clk, rst_n   : clock, synchronous active-low reset
//   in_en        : beat present; accepted while sample_vld is low
//   iot_in       : beat data
//   sample_take  : parent has evaluated the held sample
//   beat_first   : a beat is being accepted and it is beat 0 of a sample
//   sample_vld   : complete sample waiting for evaluation (also the busy flag)
//   sample_q     : assembled sample
module iot_filt_deser #(
    parameter int DATA_W = 128,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic [IN_W-1:0]   iot_in,
    input  logic              sample_take,
    output logic              beat_first,
    output logic              sample_vld,
    output logic [DATA_W-1:0] sample_q
);
    localparam int BEATS = DATA_W / IN_W;
    localparam int BC_W  = $clog2(BEATS);

    logic [BC_W-1:0] beat_cnt;
    logic            beat_acc;
    logic            beat_last;

    assign beat_acc   = in_en && !sample_vld;
    assign beat_last  = (beat_cnt == BC_W'(BEATS - 1));
    assign beat_first = beat_acc && (beat_cnt == '0);

    // The shift register doubles as the sample holding register: no beat can
    // be accepted while sample_vld is high, so it stays stable until taken.
    // Set and take never coincide because acceptance is blocked while valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            sample_q   <= '0;
            sample_vld <= 1'b0;
        end else begin
            if (beat_acc) begin
                sample_q <= {sample_q[DATA_W-IN_W-1:0], iot_in};
                beat_cnt <= beat_last ? '0 : beat_cnt + BC_W'(1);
            end
            if (beat_acc && beat_last) begin
                sample_vld <= 1'b1;
            end else if (sample_take) begin
                sample_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iot_filter_engine.sv
// iot_filter_engine
// Streaming filter: beats are deserialised into samples, samples are grouped
// into rounds of ROUND, and the function latched at round start decides what
// reaches the ready/valid output.
// Build option: IOT_FILT_AVG_ROUND_EN makes AVG round half up instead of
// truncating.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_en, iot_in     : beat input, accepted when in_en && !busy
//   fn_sel            : function code (iot_filt_pkg::fn_e), latched per round
//   thr_lo, thr_hi    : extract/exclude bounds, sampled at evaluation
//   busy              : sample pending evaluation, beats refused
//   out_valid/out_ready/iot_out : result handshake, iot_out held while stalled
module iot_filter_engine
    import iot_filt_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int IN_W   = 8,
    parameter int ROUND  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic [IN_W-1:0]   iot_in,
    input  logic [2:0]        fn_sel,
    input  logic [DATA_W-1:0] thr_lo,
    input  logic [DATA_W-1:0] thr_hi,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] iot_out
);
    localparam int LG_R  = $clog2(ROUND);
    localparam int SUM_W = DATA_W + LG_R;

    logic              beat_first;
    logic              eval_vld;
    logic [DATA_W-1:0] sample_q;
    logic              eval_fire;
    logic              round_end;
    logic              round_start;
    logic [LG_R-1:0]   round_cnt;
    fn_e               fn_q;
    fn_e               fn_new;
    logic [DATA_W-1:0] max_q, min_q, new_max, new_min, res_data;
    logic [SUM_W-1:0]  sum_q, sum_tot, avg_src;
    logic              peak_upd, gt_max, lt_min, res_vld;

    iot_filt_deser #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W)
    ) u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_en       (in_en),
        .iot_in      (iot_in),
        .sample_take (eval_fire),
        .beat_first  (beat_first),
        .sample_vld  (eval_vld),
        .sample_q    (sample_q)
    );

    assign busy        = eval_vld;
    assign eval_fire   = eval_vld && (!out_valid || out_ready);
    assign round_end   = (round_cnt == LG_R'(ROUND - 1));
    assign round_start = beat_first && (round_cnt == '0);
    assign fn_new      = fn_e'(fn_sel);
    assign gt_max      = (sample_q > max_q);
    assign lt_min      = (sample_q < min_q);
    assign new_max     = gt_max ? sample_q : max_q;
    assign new_min     = lt_min ? sample_q : min_q;
    assign sum_tot     = sum_q + SUM_W'(sample_q);

    // The sum of ROUND full-scale samples plus ROUND/2 still fits SUM_W bits.
`ifdef IOT_FILT_AVG_ROUND_EN
    assign avg_src = sum_tot + SUM_W'(ROUND / 2);
`else
    assign avg_src = sum_tot;
`endif

    // Result of evaluating the held sample under the latched function.
    // Peak functions report at round end only if the extreme strictly
    // improved at some point in the round, including this last sample.
    always_comb begin
        res_vld  = 1'b0;
        res_data = sample_q;
        case (fn_q)
            FN_MAX:     begin res_vld = round_end; res_data = new_max; end
            FN_MIN:     begin res_vld = round_end; res_data = new_min; end
            FN_AVG:     begin res_vld = round_end; res_data = DATA_W'(avg_src >> LG_R); end
            FN_EXTRACT: res_vld = (sample_q > thr_lo) && (sample_q < thr_hi);
            FN_EXCLUDE: res_vld = (sample_q < thr_lo) || (sample_q > thr_hi);
            FN_PEAKMAX: begin res_vld = round_end && (peak_upd || gt_max); res_data = new_max; end
            FN_PEAKMIN: begin res_vld = round_end && (peak_upd || lt_min); res_data = new_min; end
            default:    ;
        endcase
    end

    // Round bookkeeping, accumulators and the output register.
    // The function latch only moves on a beat accept and evaluation cannot
    // happen in that cycle (busy blocks beats), so the identity reset on a
    // function change never races with an accumulator update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round_cnt <= '0;
            fn_q      <= FN_IDLE;
            max_q     <= '0;
            min_q     <= '1;
            sum_q     <= '0;
            peak_upd  <= 1'b0;
            out_valid <= 1'b0;
            iot_out   <= '0;
        end else begin
            if (round_start) begin
                fn_q <= fn_new;
                if (fn_new != fn_q) begin
                    max_q    <= '0;
                    min_q    <= '1;
                    sum_q    <= '0;
                    peak_upd <= 1'b0;
                end
            end

            if (eval_fire) begin
                round_cnt <= round_cnt + LG_R'(1);
                case (fn_q)
                    FN_MAX: max_q <= round_end ? '0 : new_max;
                    FN_MIN: min_q <= round_end ? '1 : new_min;
                    FN_AVG: sum_q <= round_end ? '0 : sum_tot;
                    FN_PEAKMAX: begin
                        max_q    <= new_max;
                        peak_upd <= round_end ? 1'b0 : (peak_upd || gt_max);
                    end
                    FN_PEAKMIN: begin
                        min_q    <= new_min;
                        peak_upd <= round_end ? 1'b0 : (peak_upd || lt_min);
                    end
                    default: ;
                endcase
            end

            // A new result may replace one being consumed in the same cycle.
            if (eval_fire && res_vld) begin
                out_valid <= 1'b1;
                iot_out   <= res_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iot_filter_engine.sv
// tb_iot_filter_engine
// Self-checking bench for iot_filter_engine (DATA_W=128, IN_W=8, ROUND=8).
// A round-level reference model predicts the result stream; a monitor just
// before each rising edge records every accepted result. Honours the
// IOT_FILT_AVG_ROUND_EN build option in the AVG model.
module tb_iot_filter_engine;
    import iot_filt_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [127:0] thr_lo;
    logic [127:0] thr_hi;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] iot_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] smp [8];
    logic [127:0] obs_q [$];
    logic [127:0] exp_q [$];

    fn_e          m_prev;
    logic [127:0] m_pkmax;
    logic [127:0] m_pkmin;

    iot_filter_engine #(.DATA_W(128), .IN_W(8), .ROUND(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_en     (in_en),
        .iot_in    (iot_in),
        .fn_sel    (fn_sel),
        .thr_lo    (thr_lo),
        .thr_hi    (thr_hi),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .iot_out   (iot_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Records each result handshake one time unit before the edge that takes it.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) obs_q.push_back(iot_out);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired, simulation stuck");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_prev  = FN_IDLE;
        m_pkmax = '0;
        m_pkmin = '1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_beat(input logic [7:0] b, input logic [2:0] f);
        int guard;
        guard  = 0;
        in_en  = 1'b1;
        iot_in = b;
        fn_sel = f;
        while (busy && guard < 64) begin
            step();
            guard++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL beat_timeout busy=%0b required 0", busy);
        end
        step();
    endtask

    task automatic send_sample(input logic [127:0] v, input logic [2:0] f0);
        for (int b = 0; b < 16; b++) begin
            send_beat(v[127-8*b -: 8], (b == 0) ? f0 : 3'($urandom_range(0, 7)));
        end
    endtask

    // Sends smp[0..7] as one round; only the first beat carries the real code.
    task automatic send_round(input fn_e f);
        for (int i = 0; i < 8; i++) begin
            send_sample(smp[i], (i == 0) ? f : 3'($urandom_range(0, 7)));
        end
        in_en = 1'b0;
    endtask

    // Round-level reference: extremes and sums over the whole round at once.
    task automatic model_round(input fn_e f);
        logic [127:0] mx;
        logic [127:0] mn;
        logic [130:0] sm;
        if (f != m_prev) begin
            m_pkmax = '0;
            m_pkmin = '1;
        end
        m_prev = f;
        mx = '0;
        mn = '1;
        sm = '0;
        for (int i = 0; i < 8; i++) begin
            if (smp[i] > mx) mx = smp[i];
            if (smp[i] < mn) mn = smp[i];
            sm = sm + 131'(smp[i]);
        end
        case (f)
            FN_MAX: exp_q.push_back(mx);
            FN_MIN: exp_q.push_back(mn);
            FN_AVG: begin
`ifdef IOT_FILT_AVG_ROUND_EN
                sm = sm + 131'd4;
`endif
                exp_q.push_back(sm[130:3]);
            end
            FN_EXTRACT: for (int i = 0; i < 8; i++)
                if (smp[i] > thr_lo && smp[i] < thr_hi) exp_q.push_back(smp[i]);
            FN_EXCLUDE: for (int i = 0; i < 8; i++)
                if (smp[i] < thr_lo || smp[i] > thr_hi) exp_q.push_back(smp[i]);
            FN_PEAKMAX: if (mx > m_pkmax) begin exp_q.push_back(mx); m_pkmax = mx; end
            FN_PEAKMIN: if (mn < m_pkmin) begin exp_q.push_back(mn); m_pkmin = mn; end
            default: ;
        endcase
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_en = 1'b1;
        iot_in = 8'hA5;
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (iot_out !== '0) begin n_err++; $display("[TB] FAIL reset_out got %h want 0", iot_out); end
        in_en = 1'b0;
    endtask

    task automatic test_max();
        int vals [8] = '{3, 8, 1, 7, 2, 6, 5, 4};
        do_reset();
        for (int i = 0; i < 8; i++) smp[i] = 128'(vals[i]);
        send_round(FN_MAX);
        model_round(FN_MAX);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL max_busy_after_last got %0b want 1", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL max_valid_early got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL max_valid got %0b want 1", out_valid); end
        n_cmp++; if (iot_out !== 128'd8) begin n_err++; $display("[TB] FAIL max_value got %h want 8", iot_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL max_busy_drop got %0b want 0", busy); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL max_pulse got %0b want 0", out_valid); end
        for (int i = 0; i < 8; i++) smp[i] = 128'($urandom_range(0, 7));
        send_round(FN_MAX);
        model_round(FN_MAX);
        for (int i = 0; i < 8; i++) smp[i] = rnd128();
        send_round(FN_MAX);
        model_round(FN_MAX);
        repeat (4) step();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL max_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL max_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_avg();
        do_reset();
        for (int i = 0; i < 8; i++) smp[i] = 128'(i + 1);
        send_round(FN_AVG);
        model_round(FN_AVG);
        for (int i = 0; i < 8; i++) smp[i] = rnd128();
        send_round(FN_AVG);
        model_round(FN_AVG);
        repeat (4) step();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL avg_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL avg_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_extract();
        logic [127:0] lo;
        logic [127:0] hi;
        do_reset();
        lo = EXTRACT_LO;
        hi = EXTRACT_HI;
        thr_lo = lo;
        thr_hi = hi;
        smp[0] = {4'h8, 124'd0};
        smp[1] = lo;
        smp[2] = hi;
        smp[3] = lo + 128'd1;
        smp[4] = hi - 128'd1;
        for (int i = 5; i < 8; i++) smp[i] = rnd128();
        send_round(FN_EXTRACT);
        model_round(FN_EXTRACT);
        repeat (4) step();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL extract_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL extract_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        thr_lo = EXCLUDE_LO;
        thr_hi = EXCLUDE_HI;
        smp[0] = {4'h0, rnd128() >> 4};
        smp[1] = {4'hF, rnd128() >> 4};
        smp[2] = {4'h1, rnd128() >> 4};
        smp[3] = EXCLUDE_LO;
        smp[4] = EXCLUDE_HI;
        for (int i = 5; i < 8; i++) smp[i] = {4'h8, rnd128() >> 4};
        out_ready = 1'b0;
        send_sample(smp[0], FN_EXCLUDE);
        send_sample(smp[1], 3'($urandom_range(0, 7)));
        in_en = 1'b0;
        repeat (4) step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL bp_busy_held got %0b want 1", busy); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid_held got %0b want 1", out_valid); end
        n_cmp++; if (iot_out !== smp[0]) begin n_err++; $display("[TB] FAIL bp_first_held got %h want %h", iot_out, smp[0]); end
        in_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iot_in = 8'($urandom());
            step();
        end
        in_en = 1'b0;
        n_cmp++; if (iot_out !== smp[0]) begin n_err++; $display("[TB] FAIL bp_stable got %h want %h", iot_out, smp[0]); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (iot_out !== smp[1]) begin n_err++; $display("[TB] FAIL bp_second got %h want %h", iot_out, smp[1]); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_b2b_valid got %0b want 1", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL bp_busy_drop got %0b want 0", busy); end
        repeat (2) step();
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_drain got %0b want 0", out_valid); end
        for (int i = 2; i < 8; i++) send_sample(smp[i], 3'($urandom_range(0, 7)));
        in_en = 1'b0;
        model_round(FN_EXCLUDE);
        repeat (4) step();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL bp_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_peakmax();
        do_reset();
        for (int i = 0; i < 8; i++) smp[i] = 128'($urandom_range(1, 5));
        smp[3] = 128'd5;
        send_round(FN_PEAKMAX);
        model_round(FN_PEAKMAX);
        for (int i = 0; i < 8; i++) smp[i] = 128'($urandom_range(0, 5));
        send_round(FN_PEAKMAX);
        model_round(FN_PEAKMAX);
        for (int i = 0; i < 8; i++) smp[i] = 128'($urandom_range(0, 9));
        smp[6] = 128'd9;
        send_round(FN_PEAKMAX);
        model_round(FN_PEAKMAX);
        repeat (4) step();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL peak_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL peak_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) smp[i] = rnd128() | 128'd1;
        send_round(FN_MAX);
        repeat (2) step();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_pre_valid got %0b want 1", out_valid); end
        for (int b = 0; b < 6; b++) send_beat(8'($urandom()), FN_AVG);
        rst_n  = 1'b0;
        in_en  = 1'b1;
        iot_in = 8'($urandom());
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_valid got %0b want 0", out_valid); end
        n_cmp++; if (iot_out !== '0) begin n_err++; $display("[TB] FAIL rmid_out got %h want 0", iot_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_busy got %0b want 0", busy); end
        in_en = 1'b0;
        do_reset();
        out_ready = 1'b1;
        smp[0] = {8'h00, rnd128() >> 8};
        for (int i = 1; i < 8; i++) smp[i] = {8'h80, rnd128() >> 8};
        send_round(FN_MIN);
        model_round(FN_MIN);
        repeat (4) step();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL rmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL rmid_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_mix();
        fn_e fl [11] = '{FN_PEAKMIN, FN_PEAKMIN, FN_PEAKMIN, FN_MIN, FN_EXCLUDE, FN_IDLE,
                         FN_MAX, FN_AVG, FN_EXTRACT, FN_PEAKMAX, FN_PEAKMAX};
        fn_e f;
        do_reset();
        for (int r = 0; r < 16; r++) begin
            f = (r < 11) ? fl[r] : fn_e'(3'($urandom_range(0, 7)));
            thr_lo = rnd128() >> 2;
            thr_hi = thr_lo + (rnd128() >> 1);
            for (int i = 0; i < 8; i++) smp[i] = rnd128() >> (8 * $urandom_range(0, 3));
            send_round(f);
            model_round(f);
        end
        repeat (4) step();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL mix_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL mix_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_en     = 1'b0;
        iot_in    = '0;
        fn_sel    = '0;
        thr_lo    = '0;
        thr_hi    = '0;
        out_ready = 1'b1;
        test_reset();
        test_max();
        test_avg();
        test_extract();
        test_backpressure();
        test_peakmax();
        test_reset_mid();
        test_random_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
